// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, skid states and the Rijndael ShiftRows permutation
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int MAX_NB = 8;
  localparam int MAX_DW = 32 * MAX_NB;

  // Encoding is {mvalid, svalid}; {0,1} is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  function automatic int shift_offset(input int nb, input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  // State is right-aligned in the 256-bit word; byte 0 sits at bit nb*32-1.
  function automatic logic [MAX_DW-1:0] shift_rows_fn(input logic [MAX_DW-1:0] state,
                                                      input int nb, input logic inv);
    logic [MAX_DW-1:0] res;
    byte_t             b;
    int                src;
    int                top;
    res = '0;
    top = nb * 32 - 1;
    for (int c = 0; c < MAX_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (c < nb) begin
          if (inv) src = (c - shift_offset(nb, r) + nb) % nb;
          else     src = (c + shift_offset(nb, r)) % nb;
          b = state[top - 8 * (4 * src + r) -: 8];
          res[top - 8 * (4 * c + r) -: 8] = b;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// rtl/aes_skid_buf.sv - 2-entry valid/ready register slice; ready depends only on local state
module aes_skid_buf
  import aes_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic [1:0]   occupancy
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] skid_q;
  logic         accept, drain;
  logic         ld_main_in, ld_main_skid, ld_skid;

  assign m_tvalid  = state_q[1];
  assign s_tready  = ~state_q[0];
  assign occupancy = {1'b0, state_q[1]} + {1'b0, state_q[0]};
  assign accept    = s_tvalid & ~state_q[0];
  assign drain     = state_q[1] & m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SKID_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (accept) state_d = SKID_ONE;
        SKID_ONE: begin
          if (accept && !drain)      state_d = SKID_FULL;
          else if (!accept && drain) state_d = SKID_EMPTY;
        end
        SKID_FULL:  if (drain) state_d = SKID_ONE;
        default:    state_d = SKID_EMPTY;
      endcase
    end
  end

  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (!flush) begin
      case (state_q)
        SKID_EMPTY: ld_main_in = accept;
        SKID_ONE: begin
          ld_main_in = accept & drain;
          ld_skid    = accept & ~drain;
        end
        SKID_FULL:  ld_main_skid = drain;
        default: ;
      endcase
    end
  end

  // Flush only clears the valid state; payload registers keep stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata <= '0;
      skid_q  <= '0;
    end else begin
      if (ld_main_in)        m_tdata <= s_tdata;
      else if (ld_main_skid) m_tdata <= skid_q;
      if (ld_skid)           skid_q  <= s_tdata;
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// rtl/aes_shift_rows_pipe.sv - ShiftRows/InvShiftRows round stage, NB = 4/6/8, tag sideband
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter  int NB    = 4,
  parameter  int TAG_W = 4,
  localparam int DW    = 32 * NB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  logic [MAX_DW-1:0]   state_ext;
  logic [MAX_DW-1:0]   shifted_ext;
  logic [DW+TAG_W-1:0] slot_in;
  logic [DW+TAG_W-1:0] slot_out;

  // Permute before the register slice so both slots hold finished results.
  assign state_ext   = MAX_DW'(in_data);
  assign shifted_ext = shift_rows_fn(state_ext, NB, in_inv);
  assign slot_in     = {shifted_ext[DW-1:0], in_tag};

  if (DW < MAX_DW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^shifted_ext[MAX_DW-1:DW];
  end

  aes_skid_buf #(
    .W(DW + TAG_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .s_tvalid (in_valid),
    .s_tready (in_ready),
    .s_tdata  (slot_in),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (slot_out),
    .occupancy(occupancy)
  );

  assign out_data = slot_out[DW+TAG_W-1:TAG_W];
  assign out_tag  = slot_out[TAG_W-1:0];

endmodule
